// File: rtl/uart_pkg.sv
// Shared constants for the UART core: frame-format codes and FSM state encodings.
package uart_pkg;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    function automatic logic par_on(input logic [1:0] p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

    // Index of the last data bit (4..7) for a dbits code.
    function automatic logic [2:0] dbits_last(input logic [1:0] d);
        return {1'b1, d};
    endfunction

    function automatic logic [7:0] dbits_mask(input logic [1:0] d);
        return 8'hFF >> (2'd3 - d);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick divider: one-cycle pulse every cfg_div+1 clocks.
module uart_os_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             os_tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    // The period is re-captured only at the wrap so a mid-period change cannot truncate a tick.
    assign os_tick = (cnt >= div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= cfg_div;
        end else if (os_tick) begin
            cnt   <= '0;
            div_q <= cfg_div;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core_param.sv
// UART core: one TX and one RX channel sharing an oversampling divider, run-time frame format.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int OS_RATE     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_dbits,
    input  logic [1:0]       cfg_par,
    input  logic             cfg_stop2,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             tx_busy,
    output logic             rs232_tx,
    input  logic             rs232_rx,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_overrun
);

    localparam int TC_W = $clog2(OS_RATE);
    localparam logic [TC_W-1:0] T_LAST = TC_W'(OS_RATE - 1);
    localparam logic [TC_W-1:0] T_END  = TC_W'(OS_RATE - 2);
    localparam logic [TC_W-1:0] S_LO   = TC_W'(OS_RATE / 2 - 1);
    localparam logic [TC_W-1:0] S_MID  = TC_W'(OS_RATE / 2);
    localparam logic [TC_W-1:0] S_HI   = TC_W'(OS_RATE / 2 + 1);

    logic os_tick;

    uart_os_tick #(.DIV_W(DIV_W)) u_os_tick (
        .clk     (clk),
        .rst     (rst),
        .cfg_div (cfg_div),
        .os_tick (os_tick)
    );

    // ---------------- TX ----------------
    tx_state_t       tx_state, tx_nxt;
    logic            tx_wait, tx_wait_nxt, tx_line_nxt, tx_accept, tx_parity;
    logic [TC_W-1:0] tx_tcnt, tx_tcnt_nxt;
    logic [2:0]      tx_bcnt, tx_bcnt_nxt;
    logic [7:0]      tx_buf;
    logic [1:0]      tx_dbits_q, tx_par_q;
    logic            tx_stop2_q;

    assign tx_ready  = (tx_state == TX_IDLE);
    assign tx_busy   = !tx_ready;
    assign tx_parity = (^tx_buf) ^ (tx_par_q == PAR_ODD);

    // The final stop state ends one tick early so a queued frame starts with no idle gap.
    always_comb begin
        tx_nxt      = tx_state;
        tx_wait_nxt = tx_wait;
        tx_tcnt_nxt = tx_tcnt;
        tx_bcnt_nxt = tx_bcnt;
        tx_line_nxt = rs232_tx;
        tx_accept   = 1'b0;
        if (tx_state == TX_IDLE) begin
            if (tx_valid) begin
                tx_accept   = 1'b1;
                tx_nxt      = TX_START;
                tx_wait_nxt = 1'b1;
            end
        end else if (os_tick) begin
            tx_tcnt_nxt = tx_tcnt + 1'b1;
            if (tx_wait) begin
                tx_wait_nxt = 1'b0;
                tx_line_nxt = 1'b0;
                tx_tcnt_nxt = '0;
            end else if ((tx_state == TX_STOP1 && !tx_stop2_q && tx_tcnt == T_END) ||
                         (tx_state == TX_STOP2 && tx_tcnt == T_END)) begin
                tx_nxt = TX_IDLE;
            end else if (tx_tcnt == T_LAST) begin
                tx_tcnt_nxt = '0;
                case (tx_state)
                    TX_START: begin
                        tx_nxt      = TX_DATA;
                        tx_bcnt_nxt = '0;
                        tx_line_nxt = tx_buf[0];
                    end
                    TX_DATA: begin
                        if (tx_bcnt == dbits_last(tx_dbits_q)) begin
                            tx_nxt      = par_on(tx_par_q) ? TX_PARITY : TX_STOP1;
                            tx_line_nxt = par_on(tx_par_q) ? tx_parity : 1'b1;
                        end else begin
                            tx_bcnt_nxt = tx_bcnt + 3'd1;
                            tx_line_nxt = tx_buf[tx_bcnt + 3'd1];
                        end
                    end
                    TX_PARITY: begin
                        tx_nxt      = TX_STOP1;
                        tx_line_nxt = 1'b1;
                    end
                    TX_STOP1: tx_nxt = TX_STOP2;
                    default:  tx_nxt = TX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_wait    <= 1'b0;
            tx_tcnt    <= '0;
            tx_bcnt    <= '0;
            rs232_tx   <= 1'b1;
            tx_buf     <= '0;
            tx_dbits_q <= DBITS_8;
            tx_par_q   <= PAR_NONE;
            tx_stop2_q <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            tx_wait  <= tx_wait_nxt;
            tx_tcnt  <= tx_tcnt_nxt;
            tx_bcnt  <= tx_bcnt_nxt;
            rs232_tx <= tx_line_nxt;
            if (tx_accept) begin
                tx_buf     <= tx_data & dbits_mask(cfg_dbits);
                tx_dbits_q <= cfg_dbits;
                tx_par_q   <= cfg_par;
                tx_stop2_q <= cfg_stop2;
            end
        end
    end

    // ---------------- RX ----------------
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s, rx_prev;

    assign rx_s = rx_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], rs232_rx};
            rx_prev <= rx_s;
        end
    end

    rx_state_t       rx_state, rx_nxt;
    logic [TC_W-1:0] rx_tcnt, rx_tcnt_nxt;
    logic [2:0]      rx_bcnt, rx_bcnt_nxt;
    logic [1:0]      rx_votes, rx_votes_nxt;
    logic            rx_maj, rx_start, rx_bit_done, rx_done;
    logic [7:0]      rx_buf;
    logic [1:0]      rx_dbits_q, rx_par_q;
    logic            rx_par_bad, rx_stop_bad, rx_commit;

    // Two votes are banked; the third sample is the live line.
    assign rx_maj = rx_votes[1] | (rx_votes[0] & rx_s);

    always_comb begin
        rx_nxt       = rx_state;
        rx_tcnt_nxt  = rx_tcnt;
        rx_bcnt_nxt  = rx_bcnt;
        rx_votes_nxt = rx_votes;
        rx_start     = 1'b0;
        rx_bit_done  = 1'b0;
        rx_done      = 1'b0;
        if (rx_state == RX_IDLE) begin
            if (rx_prev && !rx_s) begin
                rx_nxt       = RX_START;
                rx_tcnt_nxt  = '0;
                rx_votes_nxt = '0;
                rx_start     = 1'b1;
            end
        end else if (os_tick) begin
            rx_tcnt_nxt = rx_tcnt + 1'b1;
            if (rx_tcnt == S_LO || rx_tcnt == S_MID)
                rx_votes_nxt = rx_votes + {1'b0, rx_s};
            if (rx_tcnt == S_HI) begin
                rx_bit_done  = 1'b1;
                rx_votes_nxt = '0;
                if (rx_state == RX_START && rx_maj)
                    rx_nxt = RX_IDLE;
                if (rx_state == RX_STOP) begin
                    rx_nxt  = RX_IDLE;
                    rx_done = 1'b1;
                end
            end
            if (rx_tcnt == T_LAST) begin
                rx_tcnt_nxt = '0;
                case (rx_state)
                    RX_START: begin
                        rx_nxt      = RX_DATA;
                        rx_bcnt_nxt = '0;
                    end
                    RX_DATA: begin
                        if (rx_bcnt == dbits_last(rx_dbits_q))
                            rx_nxt = par_on(rx_par_q) ? RX_PARITY : RX_STOP;
                        else
                            rx_bcnt_nxt = rx_bcnt + 3'd1;
                    end
                    RX_PARITY: rx_nxt = RX_STOP;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_tcnt       <= '0;
            rx_bcnt       <= '0;
            rx_votes      <= '0;
            rx_buf        <= '0;
            rx_dbits_q    <= DBITS_8;
            rx_par_q      <= PAR_NONE;
            rx_par_bad    <= 1'b0;
            rx_stop_bad   <= 1'b0;
            rx_commit     <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_state  <= rx_nxt;
            rx_tcnt   <= rx_tcnt_nxt;
            rx_bcnt   <= rx_bcnt_nxt;
            rx_votes  <= rx_votes_nxt;
            rx_commit <= rx_done;
            if (rx_start) begin
                rx_buf     <= '0;
                rx_par_bad <= 1'b0;
                rx_dbits_q <= cfg_dbits;
                rx_par_q   <= cfg_par;
            end
            if (rx_bit_done) begin
                case (rx_state)
                    RX_DATA:   rx_buf[rx_bcnt] <= rx_maj;
                    RX_PARITY: rx_par_bad      <= rx_maj ^ (^rx_buf) ^ (rx_par_q == PAR_ODD);
                    RX_STOP:   rx_stop_bad     <= !rx_maj;
                    default:   ;
                endcase
            end
            // An unread word wins over a new one unless it is popped in the same cycle.
            if (rx_commit) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data       <= rx_buf;
                    rx_parity_err <= rx_par_bad;
                    rx_frame_err  <= rx_stop_bad;
                    rx_valid      <= 1'b1;
                    rx_overrun    <= 1'b0;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: TX waveform, loopback, RX errors, overrun, glitches, reset.
module tb_uart_core_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_dbits, cfg_par;
    logic        cfg_stop2;
    logic        tx_valid, tx_ready, tx_busy, rs232_tx, rs232_rx;
    logic [7:0]  tx_data, rx_data;
    logic        rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun;
    logic        rx_drv, loopback;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;
    int t_rise = 0;
    int n_commit = 0;
    logic valid_q = 1'b0;
    logic [9:0] exp_bits;

    assign rs232_rx = loopback ? rs232_tx : rx_drv;

    uart_core_param dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_div       (cfg_div),
        .cfg_dbits     (cfg_dbits),
        .cfg_par       (cfg_par),
        .cfg_stop2     (cfg_stop2),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .rs232_tx      (rs232_tx),
        .rs232_rx      (rs232_rx),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        valid_q <= rx_valid;
        if (rx_valid && !valid_q) t_rise <= cyc;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(negedge clk);
        while (cyc[0]) @(negedge clk);
        t_start = cyc;
    endtask

    // Bench-side serializer: start, nb data bits LSB first, optional parity, one stop bit.
    task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                              input bit bad_par, input bit stop_val, input int glitch_idx);
        logic [11:0] bits;
        int n;
        logic p;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin bits[n] = d[i]; n++; end
        if (par != 0) begin
            p = 1'b0;
            for (int i = 0; i < nb; i++) p = p ^ d[i];
            if (par == 2) p = ~p;
            bits[n] = p ^ bad_par; n++;
        end
        bits[n] = stop_val; n++;
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            if (i == glitch_idx) begin
                repeat (16) @(negedge clk);
                rx_drv = ~bits[i];
                @(negedge clk);
                rx_drv = bits[i];
                repeat (15) @(negedge clk);
            end else begin
                repeat (32) @(negedge clk);
            end
        end
        rx_drv = 1'b1;
    endtask

    task automatic send_tx(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_idle(input string tag);
        int n = 0;
        while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
        chk(tag, tx_ready, 1);
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (!rx_valid && n < 2000) begin @(negedge clk); n++; end
        chk(tag, rx_valid, 1);
    endtask

    task automatic wait_tx_fall(input string tag);
        int n = 0;
        while (rs232_tx !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        chk(tag, rs232_tx, 0);
    endtask

    task automatic pop(input string tag);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk(tag, rx_valid, 0);
    endtask

    task automatic set_cfg(input logic [1:0] d, input logic [1:0] p, input logic s2);
        cfg_dbits = d;
        cfg_par   = p;
        cfg_stop2 = s2;
    endtask

    initial begin
        rst = 1'b1; cfg_div = 16'd1; tx_valid = 1'b0; tx_data = '0;
        rx_drv = 1'b1; loopback = 1'b0; rx_ready = 1'b0;
        set_cfg(2'b11, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
        chk("rst_tx_line", rs232_tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 0xA5 on the TX pin
        send_tx(8'hA5);
        chk("tx_ready_drop", tx_ready, 0);
        chk("tx_busy_set", tx_busy, 1);
        wait_tx_fall("tx_a5_start");
        exp_bits = 10'b1_1010_0101_0;
        repeat (16) @(negedge clk);
        chk("tx_a5_bit0", rs232_tx, exp_bits[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (32) @(negedge clk);
            chk($sformatf("tx_a5_bit%0d", k), rs232_tx, exp_bits[k]);
        end
        chk("tx_a5_ready_late", tx_ready, 0);
        repeat (16) @(negedge clk);
        chk("tx_a5_ready_320", tx_ready, 1);
        chk("tx_a5_busy_end", tx_busy, 0);

        // loopback 7E2 0x3C then 5O1 0xF5 (upper bits dropped -> 0x15)
        loopback = 1'b1;
        set_cfg(2'b10, 2'b01, 1'b1);
        send_tx(8'h3C);
        wait_rx("lb_7e2_valid");
        chk("lb_7e2_data", rx_data, 8'h3C);
        chk("lb_7e2_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
        pop("lb_7e2_pop");
        wait_tx_idle("lb_7e2_tx_idle");
        set_cfg(2'b00, 2'b10, 1'b0);
        send_tx(8'hF5);
        wait_rx("lb_5o1_valid");
        chk("lb_5o1_data", rx_data, 8'h15);
        chk("lb_5o1_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
        pop("lb_5o1_pop");
        wait_tx_idle("lb_5o1_tx_idle");
        loopback = 1'b0;

        // 8E1 0x81 with the parity bit inverted
        set_cfg(2'b11, 2'b01, 1'b0);
        align();
        send_frame(8'h81, 8, 1, 1'b1, 1'b1, -1);
        wait_rx("par_valid");
        chk("par_data", rx_data, 8'h81);
        chk("par_err", rx_parity_err, 1);
        chk("par_frame_ok", rx_frame_err, 0);
        pop("par_pop");

        // 8N1 0x55 with the stop bit low
        set_cfg(2'b11, 2'b00, 1'b0);
        align();
        send_frame(8'h55, 8, 0, 1'b0, 1'b0, -1);
        wait_rx("frm_valid");
        chk("frm_data", rx_data, 8'h55);
        chk("frm_err", rx_frame_err, 1);
        chk("frm_par_ok", rx_parity_err, 0);
        pop("frm_pop");
        repeat (40) @(negedge clk);

        // two words without a pop
        align();
        send_frame(8'h11, 8, 0, 1'b0, 1'b1, -1);
        align();
        send_frame(8'h22, 8, 0, 1'b0, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data_kept", rx_data, 8'h11);
        chk("ovr_flag", rx_overrun, 1);
        pop("ovr_pop_valid");
        chk("ovr_pop_clear", rx_overrun, 0);

        // 4-clk low pulse must be rejected as a false start
        align();
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (400) @(negedge clk);
        chk("false_start", rx_valid, 0);

        // 1-clk glitch in the middle of data bit 2
        align();
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 3);
        wait_rx("glitch_valid");
        chk("glitch_data", rx_data, 8'h5A);
        chk("glitch_frame_ok", rx_frame_err, 0);
        pop("glitch_pop");

        // pop in the same cycle as a commit: measure the commit slot, then replay it
        align();
        send_frame(8'h66, 8, 0, 1'b0, 1'b1, -1);
        wait_rx("sim_a_valid");
        @(negedge clk);
        n_commit = t_rise - t_start;
        chk("sim_a_data", rx_data, 8'h66);
        align();
        fork
            send_frame(8'h99, 8, 0, 1'b0, 1'b1, -1);
            begin
                repeat (n_commit - 1) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        chk("sim_valid", rx_valid, 1);
        chk("sim_data", rx_data, 8'h99);
        chk("sim_no_ovr", rx_overrun, 0);

        // reset mid-frame with an unread word and TX/RX both busy
        loopback = 1'b1;
        set_cfg(2'b11, 2'b00, 1'b0);
        send_tx(8'h00);
        wait_tx_fall("rst_mid_start");
        repeat (80) @(negedge clk);
        chk("rst_mid_tx_low", rs232_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx_high", rs232_tx, 1);
        chk("rst_mid_rx_valid", rx_valid, 0);
        chk("rst_mid_tx_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_tx(8'hC3);
        wait_rx("post_rst_valid");
        chk("post_rst_data", rx_data, 8'hC3);
        chk("post_rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
        pop("post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
